// File: rtl/grey_pkg.sv
// Shared Johnson-code helpers for the multi-digit grey counter.
// Codes are handled zero-extended to 32 bits with the live width passed as dw.
package grey_pkg;

  localparam int CODE_MAX = 32;

  function automatic logic [31:0] johnson_mask(input int dw);
    return (dw >= CODE_MAX) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
  endfunction

  function automatic logic [31:0] johnson_up(input logic [31:0] c, input int dw);
    return ((c << 1) | {31'd0, ~c[dw-1]}) & johnson_mask(dw);
  endfunction

  function automatic logic [31:0] johnson_down(input logic [31:0] c, input int dw);
    return ((c & johnson_mask(dw)) >> 1) | ({31'd0, ~c[0]} << (dw - 1));
  endfunction

  // Ones-count gives the value on the rising half; the falling half counts back from RADIX.
  function automatic int johnson_decode(input logic [31:0] c, input int dw);
    int pop;
    pop = $countones(c & johnson_mask(dw));
    return c[dw-1] ? (2 * dw - pop) : pop;
  endfunction

  function automatic logic johnson_legal(input logic [31:0] c, input int dw);
    logic [31:0] a;
    logic [31:0] b;
    a = c & johnson_mask(dw);
    b = ~c & johnson_mask(dw);
    return ((a & (a + 32'd1)) == 32'd0) || ((b & (b + 32'd1)) == 32'd0);
  endfunction

  function automatic logic params_ok(input int radix, input int digits);
    return (radix >= 4) && (radix % 2 == 0) && (radix / 2 <= CODE_MAX) && (digits >= 1);
  endfunction

endpackage

// File: rtl/johnson_digit.sv
// One Johnson-coded digit: load, scrub of illegal codes, up/down stepping and terminal flags.
module johnson_digit
  import grey_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_step,
  input  logic          i_up,
  input  logic          i_load,
  input  logic [DW-1:0] i_initCode,
  output logic [DW-1:0] o_code,
  output logic          o_termUp,
  output logic          o_termDown,
  output logic          o_liveIllegal,
  output logic          o_initIllegal
);

  logic [DW-1:0] r_code;
  logic [DW-1:0] w_upCode;
  logic [DW-1:0] w_downCode;
  logic          w_codeLegal;
  logic          w_initLegal;
  int            w_value;

  assign w_upCode    = DW'(johnson_up(32'(r_code), DW));
  assign w_downCode  = DW'(johnson_down(32'(r_code), DW));
  assign w_codeLegal = johnson_legal(32'(r_code), DW);
  assign w_initLegal = johnson_legal(32'(i_initCode), DW);
  assign w_value     = johnson_decode(32'(r_code), DW);

  // Load wins over scrub, scrub wins over stepping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_code <= '0;
    end else if (i_load) begin
      r_code <= w_initLegal ? i_initCode : '0;
    end else if (!w_codeLegal) begin
      r_code <= '0;
    end else if (i_step) begin
      r_code <= i_up ? w_upCode : w_downCode;
    end
  end

  assign o_code        = r_code;
  assign o_termUp      = (w_value == 2 * DW - 1);
  assign o_termDown    = (w_value == 0);
  assign o_liveIllegal = ~w_codeLegal;
  assign o_initIllegal = ~w_initLegal;

endmodule

// File: rtl/grey_counter_n.sv
// Multi-digit Johnson counter with up/down, load, scrub, wrap pulse, sticky error and shadow readout.
module grey_counter_n
  import grey_pkg::*;
#(
  parameter  int DIGITS = 12,
  parameter  int RADIX  = 10,
  localparam int DW     = RADIX / 2,
  localparam int BW     = $clog2(RADIX),
  localparam int SELW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_up,
  input  logic                 i_load,
  input  logic [DIGITS*DW-1:0] i_init,
  input  logic                 i_snap,
  input  logic [SELW-1:0]      i_sel,
  output logic [DIGITS*DW-1:0] o_q,
  output logic [DW-1:0]        o_rdCode,
  output logic [BW-1:0]        o_rdBin,
  output logic                 o_rdOor,
  output logic                 o_wrap,
  output logic                 o_err
);

  if (!params_ok(RADIX, DIGITS)) begin : g_badParams
    $error("grey_counter_n: RADIX must be even and >= 4, DIGITS >= 1");
  end

  logic [1:0]           r_rstSync;
  logic                 w_rst;
  logic [DIGITS*DW-1:0] w_q;
  logic [DIGITS-1:0]    w_termUp;
  logic [DIGITS-1:0]    w_termDown;
  logic [DIGITS-1:0]    w_term;
  logic [DIGITS-1:0]    w_step;
  logic [DIGITS-1:0]    w_liveIll;
  logic [DIGITS-1:0]    w_initIll;
  logic [DIGITS*DW-1:0] r_shadow;
  logic [DW-1:0]        w_selCode;
  logic [DW-1:0]        r_rdCode;
  logic [BW-1:0]        r_rdBin;
  logic                 r_rdOor;
  logic                 r_wrap;
  logic                 r_err;

  // Reset asserts immediately but releases two edges later, aligned to the clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rstSync <= 2'b11;
    else       r_rstSync <= {r_rstSync[0], 1'b0};
  end
  assign w_rst = r_rstSync[1];

  assign w_term    = i_up ? w_termUp : w_termDown;
  assign w_step[0] = i_en;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi > 0) begin : g_ripple
      assign w_step[gi] = w_step[gi-1] & w_term[gi-1];
    end
    johnson_digit #(.DW(DW)) u_digit (
      .i_clk        (i_clk),
      .i_rst        (w_rst),
      .i_step       (w_step[gi]),
      .i_up         (i_up),
      .i_load       (i_load),
      .i_initCode   (i_init[gi*DW +: DW]),
      .o_code       (w_q[gi*DW +: DW]),
      .o_termUp     (w_termUp[gi]),
      .o_termDown   (w_termDown[gi]),
      .o_liveIllegal(w_liveIll[gi]),
      .o_initIllegal(w_initIll[gi])
    );
  end

  always_comb begin
    w_selCode = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(i_sel) == i) w_selCode = r_shadow[i*DW +: DW];
    end
  end

  // Shadow, readout, wrap and sticky error share the synchronised reset.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_shadow <= '0;
      r_rdCode <= '0;
      r_rdBin  <= '0;
      r_rdOor  <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (i_snap) r_shadow <= w_q;
      r_rdOor  <= (int'(i_sel) >= DIGITS);
      r_rdCode <= w_selCode;
      r_rdBin  <= BW'(johnson_decode(32'(w_selCode), DW));
      r_wrap   <= i_en & ~i_load & (&w_term);
      r_err    <= r_err | (i_load ? (|w_initIll) : (|w_liveIll));
    end
  end

  assign o_q      = w_q;
  assign o_rdCode = r_rdCode;
  assign o_rdBin  = r_rdBin;
  assign o_rdOor  = r_rdOor;
  assign o_wrap   = r_wrap;
  assign o_err    = r_err;

endmodule
